// File: rtl/div_pkg.sv
// Shared types and constants for the sequential radix-2 divider.
package div_pkg;

    localparam int DIV_WIDTH_DEFAULT = 32;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        FIX,
        DONE
    } div_state_e;

    function automatic int div_cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

    localparam int DIV_CNT_W = div_cnt_width(DIV_WIDTH_DEFAULT);

endpackage

// File: rtl/div_seq_ctrl_if.sv
// Core <-> divider request/result bundle; `rem` exists only when DIV_REMAINDER_EN is defined.
interface div_seq_ctrl_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
);

    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] rn;
    logic [WIDTH-1:0] rm;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] y;
    logic             div_by_zero;
`ifdef DIV_REMAINDER_EN
    logic [WIDTH-1:0] rem;

    modport master (
        output start, is_signed, rn, rm,
        input  busy, done, y, div_by_zero, rem
    );

    modport slave (
        input  start, is_signed, rn, rm,
        output busy, done, y, div_by_zero, rem
    );
`else
    modport master (
        output start, is_signed, rn, rm,
        input  busy, done, y, div_by_zero
    );

    modport slave (
        input  start, is_signed, rn, rm,
        output busy, done, y, div_by_zero
    );
`endif

endinterface

// File: rtl/div_abs.sv
// Conditional two's-complement negate, used for operand magnitudes and result sign fix.
module div_abs
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] i_in,
    input  logic             i_neg_en,
    output logic [WIDTH-1:0] o_out
);

    assign o_out = i_neg_en ? -i_in : i_in;

endmodule

// File: rtl/div_seq_ctrl.sv
// Iterative restoring divider controller, one quotient bit per cycle.
// Optional remainder output enabled by defining DIV_REMAINDER_EN.
module div_seq_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input logic           clk,
    input logic           reset,
    div_seq_ctrl_if.slave bus
);

    localparam int             CNT_W     = div_cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    div_state_e       r_state;
    div_state_e       w_next_state;

    logic             r_signed;
    logic             r_q_neg;
    logic             r_r_neg;
    logic             r_dz;
    logic             r_dbz;
    logic [WIDTH-1:0] r_rn;
    logic [WIDTH-1:0] r_rm;
    logic [WIDTH-1:0] r_rm_mag;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_y;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] w_rn_mag;
    logic [WIDTH-1:0] w_rm_mag;
    logic [WIDTH-1:0] w_y_fix;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic             w_rm_zero;

    div_abs #(.WIDTH(WIDTH)) u_abs_rn (
        .i_in     (r_rn),
        .i_neg_en (r_r_neg),
        .o_out    (w_rn_mag)
    );

    div_abs #(.WIDTH(WIDTH)) u_abs_rm (
        .i_in     (r_rm),
        .i_neg_en (r_signed & r_rm[WIDTH-1]),
        .o_out    (w_rm_mag)
    );

    div_abs #(.WIDTH(WIDTH)) u_abs_quo (
        .i_in     (r_quo),
        .i_neg_en (r_q_neg),
        .o_out    (w_y_fix)
    );

`ifdef DIV_REMAINDER_EN
    logic [WIDTH-1:0] r_rem_out;
    logic [WIDTH-1:0] w_rem_fix;

    // Remainder takes the dividend's sign so that y*rm + rem == rn.
    div_abs #(.WIDTH(WIDTH)) u_abs_rem (
        .i_in     (r_rem),
        .i_neg_en (r_r_neg),
        .o_out    (w_rem_fix)
    );

    assign bus.rem = r_rem_out;
`endif

    assign w_rm_zero = (r_rm == '0);

    // The shifted-in partial remainder needs WIDTH+1 bits; the low WIDTH bits of the
    // difference are exact whenever the trial succeeds, since the result is below |rm|.
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, r_rm_mag});
    assign w_diff  = w_shift[WIDTH-1:0] - r_rm_mag;

    assign bus.y           = r_y;
    assign bus.div_by_zero = r_dbz;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        bus.busy     = 1'b1;
        bus.done     = 1'b0;
        case (r_state)
            IDLE: begin
                bus.busy = 1'b0;
                if (bus.start) begin
                    w_next_state = PREP;
                end
            end
            PREP: w_next_state = w_rm_zero ? FIX : ITER;
            ITER: begin
                if (r_cnt == LAST_ITER) begin
                    w_next_state = FIX;
                end
            end
            FIX:  w_next_state = DONE;
            DONE: begin
                bus.done     = 1'b1;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_signed  <= 1'b0;
            r_q_neg   <= 1'b0;
            r_r_neg   <= 1'b0;
            r_dz      <= 1'b0;
            r_dbz     <= 1'b0;
            r_rn      <= '0;
            r_rm      <= '0;
            r_rm_mag  <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_y       <= '0;
            r_cnt     <= '0;
`ifdef DIV_REMAINDER_EN
            r_rem_out <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_signed <= bus.is_signed;
                        r_rn     <= bus.rn;
                        r_rm     <= bus.rm;
                        r_q_neg  <= bus.is_signed & (bus.rn[WIDTH-1] ^ bus.rm[WIDTH-1]);
                        r_r_neg  <= bus.is_signed & bus.rn[WIDTH-1];
                    end
                end
                PREP: begin
                    r_rm_mag <= w_rm_mag;
                    r_cnt    <= '0;
                    r_dz     <= w_rm_zero;
                    // A zero divisor skips iteration; parking |rn| in the remainder
                    // makes the sign fix hand back rn unchanged.
                    if (w_rm_zero) begin
                        r_quo <= '0;
                        r_rem <= w_rn_mag;
                    end else begin
                        r_quo <= w_rn_mag;
                        r_rem <= '0;
                    end
                end
                ITER: begin
                    r_rem <= w_ge ? w_diff : w_shift[WIDTH-1:0];
                    r_quo <= {r_quo[WIDTH-2:0], w_ge};
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                FIX: begin
                    r_y       <= w_y_fix;
                    r_dbz     <= r_dz;
`ifdef DIV_REMAINDER_EN
                    r_rem_out <= w_rem_fix;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl: result values, latency, held outputs, busy-start and reset abort.
module tb_div_seq_ctrl;
    import div_pkg::*;

    localparam int W   = 32;
    localparam int LAT = W + 2;

    typedef struct {
        logic        sgn;
        logic [31:0] rn;
        logic [31:0] rm;
        logic [31:0] y;
        logic        dbz;
        logic [31:0] rem;
        int          lat;
    } vec_t;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;
    int   edges;
    logic [31:0] prev_y;
    logic        prev_dbz;
    vec_t        vecs[9];

    div_seq_ctrl_if #(.WIDTH(W)) bus ();

    div_seq_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        edges++;
        #1;
    endtask

    // Start is sampled on edge 0; operands are scrambled right after to show they are not re-read.
    task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.is_signed = sgn;
        bus.rn        = a;
        bus.rm        = b;
        @(posedge clk);
        edges = 0;
        #1;
        bus.start     = 1'b0;
        bus.is_signed = ~sgn;
        bus.rn        = ~a;
        bus.rm        = b ^ 32'h0000_0005;
    endtask

    task automatic finish_op(input string tag, input logic [31:0] exp_y, input logic exp_dbz,
                             input logic [31:0] exp_rem, input int exp_lat);
        while (!bus.done && edges < 200) step();
        check({tag, "_done_seen"}, 64'(bus.done), 64'(1));
        check({tag, "_latency"}, 64'(edges), 64'(exp_lat));
        check({tag, "_y"}, 64'(bus.y), 64'(exp_y));
        check({tag, "_dbz"}, 64'(bus.div_by_zero), 64'(exp_dbz));
`ifdef DIV_REMAINDER_EN
        check({tag, "_rem"}, 64'(bus.rem), 64'(exp_rem));
`else
        if (exp_rem === 32'hx) $display("unexpected unknown remainder in %s", tag);
`endif
        step();
        check({tag, "_done_pulse"}, 64'({bus.done, bus.busy}), 64'(0));
        check({tag, "_y_held"}, 64'(bus.y), 64'(exp_y));
        prev_y   = exp_y;
        prev_dbz = exp_dbz;
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        launch(v.sgn, v.rn, v.rm);
        step();
        check({tag, "_busy"}, 64'(bus.busy), 64'(1));
        check({tag, "_prev_y"}, 64'(bus.y), 64'(prev_y));
        check({tag, "_prev_dbz"}, 64'(bus.div_by_zero), 64'(prev_dbz));
        finish_op(tag, v.y, v.dbz, v.rem, v.lat);
    endtask

    initial begin
        logic seen;
        n_cmp         = 0;
        n_err         = 0;
        edges         = 0;
        prev_y        = '0;
        prev_dbz      = 1'b0;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.rn        = '0;
        bus.rm        = '0;

        vecs[0] = '{1'b1, 32'hFFFF_FFF4, 32'h0000_0002, 32'hFFFF_FFFA, 1'b0, 32'h0000_0000, LAT};
        vecs[1] = '{1'b0, 32'hFFFF_FFF4, 32'h0000_0002, 32'h7FFF_FFFA, 1'b0, 32'h0000_0000, LAT};
        vecs[2] = '{1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 32'h0000_0001, LAT};
        vecs[3] = '{1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0, 32'hFFFF_FFFF, LAT};
        vecs[4] = '{1'b0, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h1234_5678, 2};
        vecs[5] = '{1'b0, 32'h0000_000A, 32'h0000_0003, 32'h0000_0003, 1'b0, 32'h0000_0001, LAT};
        vecs[6] = '{1'b1, 32'hFFFF_FFF4, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFF4, 2};
        vecs[7] = '{1'b0, 32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 1'b0, 32'h0000_0000, LAT};
        vecs[8] = '{1'b0, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 1'b0, 32'h0000_0002, LAT};

        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 64'(bus.busy), 64'(0));
        check("reset_done", 64'(bus.done), 64'(0));
        check("reset_y", 64'(bus.y), 64'(0));
        check("reset_dbz", 64'(bus.div_by_zero), 64'(0));
`ifdef DIV_REMAINDER_EN
        check("reset_rem", 64'(bus.rem), 64'(0));
`endif
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Overflow case with a second start pulse and new operands while iterating.
        launch(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        while (edges < 5) step();
        bus.start     = 1'b1;
        bus.is_signed = 1'b0;
        bus.rn        = 32'h0000_0005;
        bus.rm        = 32'h0000_0001;
        step();
        bus.start = 1'b0;
        finish_op("ovf", 32'h8000_0000, 1'b0, 32'h0000_0000, LAT);
        seen = 1'b0;
        repeat (4) begin
            step();
            seen = seen | bus.busy | bus.done;
        end
        check("ovf_no_queued_start", 64'(seen), 64'(0));

        // Reset around iteration 10 must clear outputs immediately and suppress done.
        launch(1'b0, 32'hFFFF_FFFF, 32'h0000_0003);
        while (edges < 12) step();
        #2;
        reset = 1'b1;
        #1;
        check("abort_busy", 64'(bus.busy), 64'(0));
        check("abort_done", 64'(bus.done), 64'(0));
        check("abort_y", 64'(bus.y), 64'(0));
        check("abort_dbz", 64'(bus.div_by_zero), 64'(0));
        @(negedge clk);
        @(negedge clk);
        reset    = 1'b0;
        prev_y   = '0;
        prev_dbz = 1'b0;
        seen     = 1'b0;
        repeat (40) begin
            step();
            seen = seen | bus.done;
        end
        check("abort_no_done", 64'(seen), 64'(0));

        run_vec("after_abort", vecs[8]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/div_seq_ctrl.md
Name: div_seq_ctrl

Overview:
- Multi-cycle iterative divider controller for the execute stage.
- Sequences a radix-2 restoring shift-subtract datapath over WIDTH cycles and supports signed (two's complement) and unsigned division.
- Holds the result for the core; the core reads y when done pulses.
- Replaces a single-cycle combinational "/" so the divider no longer sets the critical path.

Parameters:
- WIDTH, 32, operand/result width in bits; must be >= 2.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
- rn  input  WIDTH  dividend; sampled with start.
- rm  input  WIDTH  divisor; sampled with start.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse; y/div_by_zero valid from this cycle.
- y  output  WIDTH  quotient; held until next accepted start.
- div_by_zero  output  1  set when the accepted rm == 0; held with y.

Behaviour:
- Reset (async, any state): state=IDLE, busy=0, done=0, y=0, div_by_zero=0, iteration counter=0, internal registers=0. Reset mid-operation aborts the division with no done pulse.
- FSM states and transitions:
  - IDLE: start=1 -> PREP. Latch is_signed, rn, rm, and the result signs: q_neg = signed & (rn[MSB]^rm[MSB]), r_neg = signed & rn[MSB].
  - PREP: compute magnitudes. In signed mode a negative operand is replaced by its two's complement; otherwise the operand is passed raw. Clear the partial remainder.
    - rm==0 -> FIX with quotient forced 0, div_by_zero=1.
    - Otherwise -> ITER with counter=0.
  - ITER: once per cycle, shift {rem,quo} left by 1 and trial-subtract |rm| from the rem (WIDTH+1-bit compare).
    - Non-negative trial: keep it and set quo[0]=1.
    - Negative trial: restore and set quo[0]=0.
    - After WIDTH iterations (counter==WIDTH-1) -> FIX.
  - FIX: apply sign. y = q_neg ? -quo : quo, truncated toward zero, WIDTH bits with wrap -> DONE.
  - DONE: done=1 for exactly this cycle -> IDLE.
- Latency, counted in rising edges after the edge that samples start:
  - Normal: done high after edge WIDTH+2 (34 for WIDTH=32).
  - Divide-by-zero: done high after edge 2.
- Throughput: a new start is accepted in the cycle after done at the earliest.
- start while busy is ignored, with no queueing. Operand changes while busy have no effect.
- rn==0 goes through the normal path and yields y=0, div_by_zero=0.
- Signed overflow: most-negative / -1 returns the most-negative value (0x80000000), with no flag.
- y and div_by_zero update only in FIX and are stable outside FIX.

Optional Feature:
- Macro DIV_REMAINDER_EN.
- Defined: adds output port rem, WIDTH bits, reset 0.
  - Remainder magnitude is negated in FIX when r_neg, so its sign follows the dividend.
  - rem = rn when rm==0.
  - Invariant: y*rm + rem == rn (mod 2^WIDTH) for every non-zero divisor.
- Undefined: no rem port. The remainder register is still used internally but not exported. Timing is identical in both builds.

Decomposition:
- Package div_pkg:
  - FSM state enum (IDLE, PREP, ITER, FIX, DONE).
  - Counter-width constant $clog2(WIDTH).
  - Default WIDTH constant.
- Sub-module div_abs: combinational conditional two's-complement negate (in, neg_en, out).
  - Instantiated for the operand magnitudes in PREP and the result sign fix in FIX.
- FSM, counter and shift/subtract datapath remain in div_seq_ctrl.

Test Plan:
- Signed basic: rn=0xFFFFFFF4, rm=0x00000002, is_signed=1 -> y=0xFFFFFFFA, div_by_zero=0, done on edge 34; with DIV_REMAINDER_EN, rem=0.
- Unsigned same operands: is_signed=0 -> y=0x7FFFFFFA.
- Mixed signs with truncation: rn=7, rm=0xFFFFFFFE (-2), signed -> y=0xFFFFFFFD (-3); rem=1 if enabled.
- Divide by zero: rn=0x12345678, rm=0 -> y=0, div_by_zero=1, done on edge 2. The next normal start (rn=10, rm=3, unsigned) clears it -> y=3, div_by_zero=0.
- Overflow and busy: 0x80000000 / 0xFFFFFFFF signed -> y=0x80000000. A second start pulse with other operands during ITER is ignored, and y is unchanged.
- Reset mid-op: assert reset during ITER (counter~10) -> busy=0 and y=0 immediately (async), no done. The following division 100/7 unsigned -> y=14.
